// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Lets two requesters share one single-ported synchronous data
//            memory.
//              - Port C is the pipeline MEM-stage LSU and has fixed priority.
//              - Port A is an auxiliary master (boot loader or debug). It gets
//                priority after STARVE_LIMIT consecutive denied cycles.
//            At most one access is granted per cycle. Read data has a latency
//            of one cycle and is returned to the port that issued the read.
//            o_c_stall drives the hazard unit.
// Ports    : i_clk, i_reset (synchronous, active-low)
//            i_c_* / o_c_*  : LSU request, grant, read response and stall
//            i_a_* / o_a_*  : auxiliary request, grant and read response
//            o_mem_*        : memory strobe, write, address, data, byte mask
//            i_mem_rdata    : memory read data, valid the cycle after a read
// Config   : DMEM_ARB_PERF_EN adds o_perf_c_stall and o_perf_a_gnt. Both are
//            saturating CNT_W-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_c_req,
    input  logic                  i_c_we,
    input  logic [ADDR_W-1:0]     i_c_addr,
    input  logic [DATA_W-1:0]     i_c_wdata,
    input  logic [DATA_W/8-1:0]   i_c_bmask,
    output logic                  o_c_gnt,
    output logic                  o_c_rvalid,
    output logic [DATA_W-1:0]     o_c_rdata,
    output logic                  o_c_stall,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic [ADDR_W-1:0]     i_a_addr,
    input  logic [DATA_W-1:0]     i_a_wdata,
    input  logic [DATA_W/8-1:0]   i_a_bmask,
    output logic                  o_a_gnt,
    output logic                  o_a_rvalid,
    output logic [DATA_W-1:0]     o_a_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_bmask,
    input  logic [DATA_W-1:0]     i_mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]      o_perf_c_stall,
    output logic [CNT_W-1:0]      o_perf_a_gnt
`endif
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        C_PRI = 1'b0,
        A_PRI = 1'b1
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_rsp_vld;
    logic                r_rsp_own;    // 1 = port A owns the pending response

    logic                w_c_gnt;
    logic                w_a_gnt;
    logic                w_rd_gnt;
    logic [WAIT_W-1:0]   w_wait_next;

    // Grants are gated by reset, so requests are ignored while reset is held.
    always_comb begin
        w_c_gnt = i_reset && i_c_req && ((r_state == C_PRI) || !i_a_req);
        w_a_gnt = i_reset && i_a_req && ((r_state == A_PRI) || !i_c_req);
    end

    assign o_c_gnt     = w_c_gnt;
    assign o_a_gnt     = w_a_gnt;
    assign o_c_stall   = i_reset && i_c_req && !w_c_gnt;

    assign o_mem_en    = w_c_gnt | w_a_gnt;
    assign o_mem_we    = w_a_gnt ? i_a_we    : i_c_we;
    assign o_mem_addr  = w_a_gnt ? i_a_addr  : i_c_addr;
    assign o_mem_wdata = w_a_gnt ? i_a_wdata : i_c_wdata;
    assign o_mem_bmask = w_a_gnt ? i_a_bmask : i_c_bmask;

    assign w_rd_gnt    = o_mem_en && !o_mem_we;

    // The starvation count starts at 1 in the first denied cycle. The state
    // machine looks at the next count value, so the STARVE_LIMIT-th denied
    // cycle moves it to A_PRI on the same clock edge.
    always_comb begin
        if (w_a_gnt || !i_a_req) begin
            w_wait_next = '0;
        end else if (r_wait == WAIT_W'(STARVE_LIMIT)) begin
            w_wait_next = r_wait;
        end else begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= C_PRI;
            r_wait    <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_own <= 1'b0;
        end else begin
            r_wait    <= w_wait_next;
            r_rsp_vld <= w_rd_gnt;
            r_rsp_own <= w_a_gnt;
            if ((r_state == A_PRI) && w_a_gnt) begin
                r_state <= C_PRI;
            end else if (w_wait_next == WAIT_W'(STARVE_LIMIT)) begin
                r_state <= A_PRI;
            end
        end
    end

    // Responses are gated by reset as well. A read granted just before reset
    // is then never reported, not even in the cycle that reset is applied.
    assign o_c_rvalid = i_reset && r_rsp_vld && !r_rsp_own;
    assign o_a_rvalid = i_reset && r_rsp_vld &&  r_rsp_own;
    assign o_c_rdata  = o_c_rvalid ? i_mem_rdata : '0;
    assign o_a_rdata  = o_a_rvalid ? i_mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] r_perf_c_stall;
    logic [CNT_W-1:0] r_perf_a_gnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_perf_c_stall <= '0;
            r_perf_a_gnt   <= '0;
        end else begin
            if (o_c_stall && (r_perf_c_stall != '1)) begin
                r_perf_c_stall <= r_perf_c_stall + CNT_W'(1);
            end
            if (w_a_gnt && (r_perf_a_gnt != '1)) begin
                r_perf_a_gnt <= r_perf_a_gnt + CNT_W'(1);
            end
        end
    end

    assign o_perf_c_stall = r_perf_c_stall;
    assign o_perf_a_gnt   = r_perf_a_gnt;
`else
    // CNT_W only sizes the counters. This keeps it referenced when they are absent.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire
